tick_sequencer: RTL
===================

Name: tick_sequencer

Overview:
- Per-tick controller for the game datapath (move, collisions, generate_point, communicate).
- Converts each divided-clock tick into an ordered sequence: direction exchange -> move -> collision check -> optional point generation.
- Each step is a start/done handshake. The block also detects a lost remote link by timeout and latches the end-of-game result.
- Sits between clk_div and the datapath blocks, in the 75 MHz clk domain.

Parameters:
- RX_TIMEOUT, 1_000_000, clk cycles allowed in WAIT_DIR for the remote direction before declaring a link error.
- STEP_TIMEOUT, 4096, clk cycles allowed in any MOVE/COLL/GEN wait before declaring a step error.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  input  1  system clock, 75 MHz
- rst  input  1  asynchronous, active-low reset
- game_active  input  1  high while mode == GAME
- tick  input  1  one-cycle pulse per game step, from clk_div
- rcvdir  input  1  one-cycle pulse: remote direction received
- move_done  input  1  one-cycle pulse: map_nxt valid
- coll_done  input  1  one-cycle pulse: collision result valid
- eaten  input  1  eaten1|eaten2; sampled with coll_done
- won_in  input  1  sampled with coll_done
- lost_in  input  1  sampled with coll_done
- draw_in  input  1  sampled with coll_done
- gen_done  input  1  one-cycle pulse: new point placed
- send_dir  output  1  one-cycle pulse: transmit local direction
- move_start  output  1  one-cycle pulse
- coll_start  output  1  one-cycle pulse
- gen_start  output  1  one-cycle pulse
- busy  output  1  high in any state other than IDLE/OVER
- won  output  1  latched result
- lost  output  1  latched result
- draw  output  1  latched result
- con_error  output  1  sticky link/step error
- overrun_cnt  output  OVR_W  ticks dropped while busy, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters 0; rcv_seen=0.
- States: IDLE, SEND, WAIT_DIR, MOVE, COLL, GEN, OVER, ERR.
- IDLE, on tick && game_active: go to SEND.
- SEND: send_dir=1 for exactly one cycle; next state WAIT_DIR. Latency from tick to send_dir is 1 cycle.
- WAIT_DIR:
  - rcvdir is captured into rcv_seen in any state from SEND onward, so early arrival is not lost.
  - When rcv_seen=1 (or rcvdir this cycle): clear rcv_seen, pulse move_start next cycle, go to MOVE.
  - Timeout counter reaching RX_TIMEOUT-1: go to ERR.
- MOVE:
  - move_done: pulse coll_start next cycle, go to COLL.
  - STEP_TIMEOUT expiry: go to ERR.
- COLL, on coll_done:
  - Latch won_in/lost_in/draw_in.
  - If any of them is 1: go to OVER. Priority draw > lost > won; only one result output is set.
  - Else if eaten: pulse gen_start, go to GEN.
  - Else: go to IDLE.
  - STEP_TIMEOUT expiry: go to ERR.
- GEN:
  - gen_done: go to IDLE.
  - STEP_TIMEOUT expiry: go to ERR.
- Each start pulse is issued exactly once per tick. The timeout counter reloads on every state entry.
- Done pulse arriving in a state that does not expect it: ignored.
- OVER: results held; no further sequencing; exits to IDLE, clearing results, when game_active falls.
- ERR: con_error=1 sticky; no start pulses; exits to IDLE, clearing con_error, when game_active falls.
- Overrun: tick while busy=1 is dropped and overrun_cnt increments, saturating at all-ones. The counter clears when game_active rises.
- game_active falling mid-sequence (any busy state): abort to IDLE next cycle; no further start pulses; rcv_seen cleared; timeout cleared.
- tick and game_active rising in the same cycle: tick is accepted.
- Reset asserted mid-sequence: immediate return to reset values, with no glitch pulses on the start outputs.

Test Plan:
- Normal tick:
  - Stimulus: game_active=1; tick at cycle 0; rcvdir at 5; move_done at 9; coll_done at 12 with eaten=0.
  - Required: send_dir at 1, move_start at 6, coll_start at 10, busy=0 at 13, gen_start never pulses.
- Eaten path:
  - Stimulus: same as normal tick with eaten=1; gen_done 7 cycles later.
  - Required: exactly one gen_start one cycle after coll_done; IDLE one cycle after gen_done.
- Early rcvdir:
  - Stimulus: rcvdir in the same cycle as send_dir.
  - Required: move_start one cycle after WAIT_DIR entry.
- Link timeout:
  - Stimulus: RX_TIMEOUT=16; no rcvdir.
  - Required: con_error=1 exactly 16 cycles after WAIT_DIR entry; stays 1 until game_active=0, then clears.
- Overrun and game end:
  - Stimulus: 3 ticks issued during MOVE.
  - Required: overrun_cnt=3.
  - Stimulus: coll_done with lost_in=1 and draw_in=1.
  - Required: draw=1, lost=0, state OVER; later ticks produce no send_dir.
- Abort:
  - Stimulus: game_active=0 during COLL, then coll_done.
  - Required: no gen_start; busy=0 next cycle.
  - Stimulus: async rst=0 mid-MOVE.
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/tick_sequencer.sv
// Per-tick sequencer for the game datapath.
// Orders direction exchange, move, collision check and point generation.
module tick_sequencer #(
    parameter int unsigned RX_TIMEOUT   = 1_000_000,
    parameter int unsigned STEP_TIMEOUT = 4096,
    parameter int unsigned OVR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_active,
    input  logic             tick,
    input  logic             rcvdir,
    input  logic             move_done,
    input  logic             coll_done,
    input  logic             eaten,
    input  logic             won_in,
    input  logic             lost_in,
    input  logic             draw_in,
    input  logic             gen_done,
    output logic             send_dir,
    output logic             move_start,
    output logic             coll_start,
    output logic             gen_start,
    output logic             busy,
    output logic             won,
    output logic             lost,
    output logic             draw,
    output logic             con_error,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int unsigned TMAX =
        (RX_TIMEOUT > STEP_TIMEOUT) ? RX_TIMEOUT : STEP_TIMEOUT;
    localparam int unsigned TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RX_LAST   = TW'(RX_TIMEOUT - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_DIR, S_MOVE,
        S_COLL, S_GEN, S_OVER, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             rcv_seen_q, rcv_seen_d;
    logic             act_q, act_d;
    logic             send_q, send_d;
    logic             mst_q, mst_d;
    logic             cst_q, cst_d;
    logic             gst_q, gst_d;
    logic             won_q, won_d;
    logic             lost_q, lost_d;
    logic             draw_q, draw_d;
    logic             err_q, err_d;
    logic             counting;
    logic             step_to;

    assign busy        = (state_q != S_IDLE) && (state_q != S_OVER);
    assign send_dir    = send_q;
    assign move_start  = mst_q;
    assign coll_start  = cst_q;
    assign gen_start   = gst_q;
    assign won         = won_q;
    assign lost        = lost_q;
    assign draw        = draw_q;
    assign con_error   = err_q;
    assign overrun_cnt = ovr_q;

    assign counting = (state_q == S_WAIT_DIR) || (state_q == S_MOVE) ||
                      (state_q == S_COLL) || (state_q == S_GEN);
    assign step_to  = (timer_q == STEP_LAST);

    // Next-state, pulse, result and counter computation.
    always_comb begin
        state_d    = state_q;
        rcv_seen_d = rcv_seen_q;
        act_d      = game_active;
        send_d     = 1'b0;
        mst_d      = 1'b0;
        cst_d      = 1'b0;
        gst_d      = 1'b0;
        won_d      = won_q;
        lost_d     = lost_q;
        draw_d     = draw_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        timer_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (tick && game_active) begin
                    state_d = S_SEND;
                    send_d  = 1'b1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_DIR;
                if (rcvdir) rcv_seen_d = 1'b1;
            end
            S_WAIT_DIR: begin
                if (rcv_seen_q || rcvdir) begin
                    rcv_seen_d = 1'b0;
                    mst_d      = 1'b1;
                    state_d    = S_MOVE;
                end else if (timer_q == RX_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_MOVE: begin
                if (move_done) begin
                    cst_d   = 1'b1;
                    state_d = S_COLL;
                end else if (step_to) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_COLL: begin
                if (coll_done) begin
                    if (draw_in) begin
                        draw_d  = 1'b1;
                        state_d = S_OVER;
                    end else if (lost_in) begin
                        lost_d  = 1'b1;
                        state_d = S_OVER;
                    end else if (won_in) begin
                        won_d   = 1'b1;
                        state_d = S_OVER;
                    end else if (eaten) begin
                        gst_d   = 1'b1;
                        state_d = S_GEN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (step_to) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_GEN: begin
                if (gen_done) begin
                    state_d = S_IDLE;
                end else if (step_to) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_OVER, S_ERR: begin
                state_d = state_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Losing game_active aborts any sequence and releases OVER/ERR.
        if (!game_active && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            rcv_seen_d = 1'b0;
            send_d     = 1'b0;
            mst_d      = 1'b0;
            cst_d      = 1'b0;
            gst_d      = 1'b0;
            won_d      = 1'b0;
            lost_d     = 1'b0;
            draw_d     = 1'b0;
            err_d      = 1'b0;
        end

        if (counting && state_d == state_q)
            timer_d = timer_q + TW'(1);

        if (game_active && !act_q)
            ovr_d = '0;
        else if (tick && busy && ovr_q != '1)
            ovr_d = ovr_q + OVR_W'(1);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            ovr_q      <= '0;
            rcv_seen_q <= 1'b0;
            act_q      <= 1'b0;
            send_q     <= 1'b0;
            mst_q      <= 1'b0;
            cst_q      <= 1'b0;
            gst_q      <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
            draw_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ovr_q      <= ovr_d;
            rcv_seen_q <= rcv_seen_d;
            act_q      <= act_d;
            send_q     <= send_d;
            mst_q      <= mst_d;
            cst_q      <= cst_d;
            gst_q      <= gst_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
            draw_q     <= draw_d;
            err_q      <= err_d;
        end
    end

endmodule
